// File: rtl/reg_dump_engine.sv
// reg_dump_engine: streams every register as {index, value} over valid/ready, then a checksum trailer
module reg_dump_engine #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  _clock,
  input  logic                  _reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, READ, SEND, TRAIL, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, oidx_q, oidx_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d, data_q, data_d;
  logic                  xfer;
  assign xfer      = out_valid && out_ready;
  assign rf_addr   = idx_q;
  assign out_index = oidx_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == SEND) || (state_q == TRAIL);
  assign out_last  = state_q == TRAIL;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oidx_d  = oidx_q;
    sum_d   = sum_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        idx_d   = '0;
        sum_d   = '0;
      end
      READ: begin
        state_d = SEND;
        data_d  = rf_data;
        oidx_d  = idx_q;
        sum_d   = sum_q + rf_data;
      end
      SEND: if (xfer) begin
        state_d = (idx_q == LAST_IDX) ? TRAIL : READ;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        data_d  = (idx_q == LAST_IDX) ? sum_q : data_q;
        oidx_d  = (idx_q == LAST_IDX) ? '0 : oidx_q;
      end
      TRAIL:   state_d = xfer ? DONE : TRAIL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      oidx_q  <= '0;
      sum_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_reg_dump_engine.sv
// tb_reg_dump_engine: randomized dumps checked against an array/arithmetic reference model
module tb_reg_dump_engine;
  localparam int N = 32;
  logic        _clock = 1'b0;
  logic        _reset, start, out_ready;
  logic        out_valid, out_last, busy, done;
  logic [4:0]  rf_addr, out_index;
  logic [31:0] rf_data, out_data;
  logic [31:0] regfile [N];
  logic [31:0] golden  [N];
  int          errors = 0;
  int          checks = 0;
  always #5 _clock = ~_clock;
  assign rf_data = regfile[rf_addr];
  reg_dump_engine #(.NUM_REGS(N), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    ._clock(_clock), ._reset(_reset), .start(start), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge _clock);
    #1;
  endtask
  task automatic load(input int mode);
    for (int i = 0; i < N; i++) begin
      golden[i]  = (mode == 0) ? 32'(i * 3) : (mode == 1) ? 32'hFFFF_FFFF : $urandom;
      regfile[i] = golden[i];
    end
  endtask
  function automatic logic [31:0] ref_sum();
    logic [31:0] s = 0;
    for (int i = 0; i < N; i++) s += golden[i];
    return s;
  endfunction
  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_addr"}, rf_addr, 0);
  endtask
  task automatic dump(input bit issue, input int bp, input int stall_at, input bit start_mid,
                      input bit hold, input bit scr);
    int          n = 0, t = 0, stall = 0;
    logic        pv = 0, pr = 0;
    logic [4:0]  pi = 0;
    logic [31:0] pd = 0;
    logic [31:0] sum = ref_sum();
    if (issue) begin
      start = 1;
      tick;
    end
    start = 0;
    check("read_busy", busy, 1);
    while (t < 3000) begin
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_index", out_index, pi);
        check("hold_data", out_data, pd);
      end
      if (done) begin
        if (bp == 0 && stall_at < 0) check("done_cycle", t, 2 * N + 1);
        break;
      end
      if (out_valid && !out_last && int'(out_index) == stall_at && stall < 5) begin
        out_ready = 0;
        stall++;
      end else out_ready = ($urandom_range(99) >= bp);
      if (scr && out_valid && !out_last) regfile[out_index] = $urandom;
      if (out_valid && out_ready) begin
        if (n < N) begin
          check("word_index", out_index, n);
          check("word_data", out_data, golden[n]);
          check("word_last", out_last, 0);
        end else begin
          check("trail_index", out_index, 0);
          check("trail_data", out_data, sum);
          check("trail_last", out_last, 1);
        end
        n++;
      end
      start = (start_mid && n == 10) || (hold && n > N);
      pv = out_valid;
      pr = out_ready;
      pi = out_index;
      pd = out_data;
      tick;
      t++;
    end
    check("dump_in_time", t < 3000, 1);
    check("transfers", n, N + 1);
    if (stall_at >= 0) check("stall_cycles", stall, 5);
    tick;
    check("idle_after_done", busy, 0);
    check("done_pulse", done, 0);
    if (hold) begin
      tick;
      check("rearm_busy", busy, 1);
      check("rearm_addr", rf_addr, 0);
      start = 0;
    end
  endtask
  initial begin
    _reset = 0;
    start = 1;
    out_ready = 1;
    load(0);
    repeat (3) begin
      tick;
      check_quiet("rst");
    end
    _reset = 1;
    tick;
    check("rel_busy", busy, 1);
    check("rel_valid", out_valid, 0);
    tick;
    check("rel_first_valid", out_valid, 1);
    _reset = 0;
    start = 0;
    tick;
    check_quiet("rst2");
    _reset = 1;
    dump(1, 0, -1, 0, 0, 0);
    dump(1, 0, 7, 0, 0, 0);
    load(1);
    dump(1, 0, -1, 0, 0, 0);
    load(2);
    dump(1, 30, -1, 0, 0, 1);
    load(0);
    dump(1, 0, -1, 1, 1, 0);
    dump(0, 0, -1, 0, 0, 0);
    load(0);
    out_ready = 1;
    start = 1;
    tick;
    start = 0;
    repeat (200) if (!(out_valid && out_index == 15)) tick;
    check("mid_at15", out_index, 15);
    _reset = 0;
    tick;
    check_quiet("mid_rst");
    _reset = 1;
    repeat (5) begin
      tick;
      check("post_busy", busy, 0);
      check("post_valid", out_valid, 0);
      check("post_done", done, 0);
    end
    repeat (3) begin
      load(2);
      dump(1, 50, -1, 0, 0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
